// File: rtl/fpu_pkg.sv
// Shared FPU definitions: F32 exponent constants, the integer-normalizer FSM
// state type and the per-step shift schedule.
package fpu_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_EXP_W  = 8;
  localparam int INT_MSB    = 31;
  localparam int NORM_STEPS = 5;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    NORM,
    DONE
  } norm_state_e;

  // Binary-search schedule: step 0 tries 16 bits, then 8, 4, 2, 1.
  function automatic logic [4:0] norm_shift(input logic [2:0] step);
    return 5'd16 >> step;
  endfunction

endpackage

// File: rtl/fpu_int_norm_step.sv
// One binary-search normalization step: if the top k bits of mag are zero,
// shift them out and account for them in the leading-zero count.
module fpu_int_norm_step (
  input  logic [31:0] mag_i,
  input  logic [5:0]  lzc_i,
  input  logic [4:0]  k_i,
  output logic [31:0] mag_o,
  output logic [5:0]  lzc_o
);

  logic [31:0] top_bits;
  logic        top_zero;

  assign top_bits = mag_i >> (6'd32 - {1'b0, k_i});
  assign top_zero = (top_bits == 32'd0);
  assign mag_o    = top_zero ? (mag_i << k_i) : mag_i;
  assign lzc_o    = top_zero ? (lzc_i + {1'b0, k_i}) : lzc_i;

endmodule

// File: rtl/fpu_int_normalize.sv
// Integer-to-F32 front end: takes the magnitude of a 32-bit integer and
// left-aligns it over five fixed cycles, producing sign, biased exponent and mantissa.
module fpu_int_normalize
  import fpu_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 I_VALID,
  output logic                 I_READY,
  input  logic [31:0]          I_DATA,
  output logic                 O_VALID,
  input  logic                 O_READY,
  output logic                 O_SIGN,
  output logic [F32_EXP_W-1:0] O_EXP,
  output logic [31:0]          O_MAN,
  output logic                 O_ZERO
);

  norm_state_e          state_q, state_d;
  logic [31:0]          mag_q, mag_d;
  logic [5:0]           lzc_q, lzc_d;
  logic [2:0]           step_q, step_d;
  logic                 sign_q, sign_d;
  logic                 o_sign_q, o_sign_d;
  logic [F32_EXP_W-1:0] o_exp_q, o_exp_d;
  logic [31:0]          o_man_q, o_man_d;
  logic                 o_zero_q, o_zero_d;

  logic [31:0] step_mag;
  logic [5:0]  step_lzc;

  fpu_int_norm_step u_step (
    .mag_i (mag_q),
    .lzc_i (lzc_q),
    .k_i   (norm_shift(step_q)),
    .mag_o (step_mag),
    .lzc_o (step_lzc)
  );

  // I_READY is gated by nRST so it reads 0 for the whole reset window.
  assign I_READY = (state_q == IDLE) && nRST;
  assign O_VALID = (state_q == DONE);
  assign O_SIGN  = o_sign_q;
  assign O_EXP   = o_exp_q;
  assign O_MAN   = o_man_q;
  assign O_ZERO  = o_zero_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    mag_d    = mag_q;
    lzc_d    = lzc_q;
    step_d   = step_q;
    sign_d   = sign_q;
    o_sign_d = o_sign_q;
    o_exp_d  = o_exp_q;
    o_man_d  = o_man_q;
    o_zero_d = o_zero_q;

    unique case (state_q)
      IDLE: begin
        if (I_VALID) begin
          mag_d   = I_DATA;
          lzc_d   = 6'd0;
          step_d  = 3'd0;
          state_d = ABS;
        end
      end
      ABS: begin
        sign_d  = SIGNED_IN && mag_q[31];
        mag_d   = sign_d ? -mag_q : mag_q;
        state_d = NORM;
      end
      NORM: begin
        mag_d  = step_mag;
        lzc_d  = step_lzc;
        step_d = step_q + 3'd1;
        if (step_q == 3'(NORM_STEPS - 1)) begin
          state_d = DONE;
          if (mag_q == 32'd0) begin
            o_sign_d = 1'b0;
            o_exp_d  = '0;
            o_man_d  = 32'd0;
            o_zero_d = 1'b1;
          end else begin
            o_sign_d = sign_q;
            o_exp_d  = F32_EXP_W'(F32_BIAS + INT_MSB - int'(step_lzc));
            o_man_d  = step_mag;
            o_zero_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (O_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mag_q    <= 32'd0;
      lzc_q    <= 6'd0;
      step_q   <= 3'd0;
      sign_q   <= 1'b0;
      o_sign_q <= 1'b0;
      o_exp_q  <= '0;
      o_man_q  <= 32'd0;
      o_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      lzc_q    <= lzc_d;
      step_q   <= step_d;
      sign_q   <= sign_d;
      o_sign_q <= o_sign_d;
      o_exp_q  <= o_exp_d;
      o_man_q  <= o_man_d;
      o_zero_q <= o_zero_d;
    end
  end

endmodule

// File: tb/tb_fpu_int_normalize.sv
// Scoreboard bench for fpu_int_normalize: signed and unsigned instances,
// directed operands, latency, stall and mid-operation reset behaviour.
module tb_fpu_int_normalize;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] man;
    logic        zero;
  } res_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic        s_iv, s_ir, s_ov, s_or, s_sign, s_zero;
  logic [31:0] s_id, s_man;
  logic [7:0]  s_exp;
  logic        u_iv, u_ir, u_ov, u_or, u_sign, u_zero;
  logic [31:0] u_id, u_man;
  logic [7:0]  u_exp;

  fpu_int_normalize #(.SIGNED_IN(1'b1)) dut_s (
    .CLK(CLK), .nRST(nRST), .I_VALID(s_iv), .I_READY(s_ir), .I_DATA(s_id),
    .O_VALID(s_ov), .O_READY(s_or), .O_SIGN(s_sign), .O_EXP(s_exp),
    .O_MAN(s_man), .O_ZERO(s_zero)
  );

  fpu_int_normalize #(.SIGNED_IN(1'b0)) dut_u (
    .CLK(CLK), .nRST(nRST), .I_VALID(u_iv), .I_READY(u_ir), .I_DATA(u_id),
    .O_VALID(u_ov), .O_READY(u_or), .O_SIGN(u_sign), .O_EXP(u_exp),
    .O_MAN(u_man), .O_ZERO(u_zero)
  );

  res_t s_q[$];
  res_t u_q[$];
  res_t s_e, u_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   s_acc_cyc = 0;
  logic s_ov_prev = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic res_t r(input logic s, input logic [7:0] e, input logic [31:0] m,
                             input logic z);
    return '{sign: s, exp: e, man: m, zero: z};
  endfunction

  // Monitor: latency and scoreboard compare at each output handshake.
  always @(negedge CLK) begin
    if (!nRST) begin
      s_ov_prev = 1'b0;
    end else begin
      if (s_iv && s_ir) s_acc_cyc = cyc;
      if (s_ov && !s_ov_prev) check("s_latency", 128'(cyc - s_acc_cyc), 128'd7);
      s_ov_prev = s_ov;
      if (s_ov && s_or) begin
        if (s_q.size() == 0) check("s_spurious_valid", 128'(s_ov), 128'd0);
        else begin
          s_e = s_q.pop_front();
          check("s_result", 128'({s_sign, s_exp, s_man, s_zero}), 128'(s_e));
        end
      end
      if (u_ov && u_or) begin
        if (u_q.size() == 0) check("u_spurious_valid", 128'(u_ov), 128'd0);
        else begin
          u_e = u_q.pop_front();
          check("u_result", 128'({u_sign, u_exp, u_man, u_zero}), 128'(u_e));
        end
      end
    end
  end

  task automatic send_s(input logic [31:0] d, input res_t e, input logic keep);
    int n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!s_ir && n < 100);
    if (!s_ir) check("s_ready_timeout", 128'(s_ir), 128'd1);
    s_iv = 1'b1;
    s_id = d;
    if (keep) s_q.push_back(e);
    @(posedge CLK); #1;
    s_iv = 1'b0;
    s_id = ~d;
  endtask

  task automatic send_u(input logic [31:0] d, input res_t e);
    int n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!u_ir && n < 100);
    if (!u_ir) check("u_ready_timeout", 128'(u_ir), 128'd1);
    u_iv = 1'b1;
    u_id = d;
    u_q.push_back(e);
    @(posedge CLK); #1;
    u_iv = 1'b0;
    u_id = ~d;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((s_q.size() + u_q.size()) != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check(name, 128'(s_q.size() + u_q.size()), 128'd0);
  endtask

  initial begin
    int nv;
    nRST = 1'b0;
    s_iv = 1'b0; s_id = 32'd0; s_or = 1'b1;
    u_iv = 1'b0; u_id = 32'd0; u_or = 1'b1;

    repeat (2) @(negedge CLK);
    check("rst_i_ready", 128'(s_ir), 128'd0);
    check("rst_outputs", 128'({s_ov, s_sign, s_exp, s_man, s_zero}), 128'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 128'(s_ir), 128'd1);

    send_s(32'h0000_0001, r(1'b0, 8'd127, 32'h8000_0000, 1'b0), 1'b1);
    send_s(32'hFFFF_FFFF, r(1'b1, 8'd127, 32'h8000_0000, 1'b0), 1'b1);
    send_s(32'h8000_0000, r(1'b1, 8'd158, 32'h8000_0000, 1'b0), 1'b1);
    send_s(32'h00FF_FFFF, r(1'b0, 8'd150, 32'hFFFF_FF00, 1'b0), 1'b1);
    send_s(32'h0000_0000, r(1'b0, 8'd0,   32'h0000_0000, 1'b1), 1'b1);
    send_s(32'hFFFF_FF00, r(1'b1, 8'd135, 32'h8000_0000, 1'b0), 1'b1);

    send_u(32'hFFFF_FFFF, r(1'b0, 8'd158, 32'hFFFF_FFFF, 1'b0));
    send_u(32'h8000_0000, r(1'b0, 8'd158, 32'h8000_0000, 1'b0));
    send_u(32'h0000_0001, r(1'b0, 8'd127, 32'h8000_0000, 1'b0));
    send_u(32'h0000_0000, r(1'b0, 8'd0,   32'h0000_0000, 1'b1));
    drain("drain_directed");

    // Downstream stall: hold O_READY low for 20 cycles in DONE.
    @(posedge CLK); #1 s_or = 1'b0;
    send_s(32'h1234_5678, r(1'b0, 8'd155, 32'h91A2_B3C0, 1'b0), 1'b1);
    nv = 0;
    while (!s_ov && nv < 20) begin
      @(negedge CLK);
      nv++;
    end
    repeat (20) begin
      @(negedge CLK);
      check("stall_hold", 128'({s_ov, s_ir, s_sign, s_exp, s_man, s_zero}),
            128'({1'b1, 1'b0, 1'b0, 8'd155, 32'h91A2_B3C0, 1'b0}));
    end
    @(posedge CLK); #1 s_or = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("stall_popped", 128'(s_q.size()), 128'd0);
    check("ready_after_handshake", 128'(s_ir), 128'd1);

    // Reset during the third NORM step abandons the operand.
    send_s(32'h00AB_CDEF, r(1'b0, 8'd0, 32'd0, 1'b0), 1'b0);
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    check("mid_rst_i_ready", 128'(s_ir), 128'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    check("mid_rst_outputs", 128'({s_ov, s_sign, s_exp, s_man, s_zero}), 128'd0);
    nv = 0;
    repeat (12) begin
      @(negedge CLK);
      if (s_ov) nv++;
    end
    check("abandoned_no_valid", 128'(nv), 128'd0);
    send_s(32'h0000_0010, r(1'b0, 8'd131, 32'h8000_0000, 1'b0), 1'b1);
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
